fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch stage: drives program_counter into the UART-loaded instruction memory,
//  waits for its load_done before fetching, and registers the returned 16-bit word plus its PC
//  into an IF/ID register for the decoder. Handles stall, taken-branch redirect/flush, halt
//  and out-of-range branch targets.
// PARAMETERS
//  PC_WIDTH    8    width of program_counter / branch_target
//  INSTR_WIDTH 16   instruction word width
//  RESET_PC    0    PC value after reset and while waiting for load
//  LAST_ADDR   31   highest valid instruction address; sequential PC wraps LAST_ADDR -> 0
// PORTS
//  CLK             in   1            system clock, all state on rising edge
//  RST             in   1            asynchronous, active-high reset
//  load_done       in   1            instruction memory fully loaded
//  instruction     in   INSTR_WIDTH  combinational read data for program_counter
//  stall           in   1            hold fetch and IF/ID register
//  branch_taken    in   1            redirect request, 1-cycle pulse from execute
//  branch_target   in   PC_WIDTH     redirect address, valid with branch_taken
//  halt            in   1            stop fetching until RST
//  program_counter out  PC_WIDTH     read address to instruction memory
//  if_instruction  out  INSTR_WIDTH  registered instruction to decode
//  if_pc           out  PC_WIDTH     PC of if_instruction
//  if_valid        out  1            if_instruction/if_pc hold a real fetch
//  running         out  1            high in RUN state
//  pc_fault        out  1            1-cycle pulse: branch_target > LAST_ADDR
// BEHAVIOUR
//  Reset (async, RST=1): state=WAIT_LOAD; program_counter=RESET_PC; if_instruction=0; if_pc=0;
//   if_valid=0; running=0; pc_fault=0. Release takes effect on next CLK edge.
//  States: WAIT_LOAD, RUN, HALTED (2-bit encoding).
//  WAIT_LOAD: PC held at RESET_PC, if_valid=0. load_done=1 sampled -> RUN next edge; first
//   fetch (word at RESET_PC) is captured on the edge after entering RUN.
//  RUN, per edge, priority highest first:
//   1 halt=1       -> HALTED; if_valid<=0; PC held.
//   2 load_done=0  -> WAIT_LOAD; PC<=RESET_PC; if_valid<=0 (memory being reloaded).
//   3 branch_taken -> if target<=LAST_ADDR: PC<=branch_target; else PC<=RESET_PC and
//                     pc_fault<=1 for one cycle. if_valid<=0 (flush in-flight fetch). Wins over stall.
//   4 stall=1      -> PC, if_instruction, if_pc, if_valid all hold.
//   5 else         -> if_instruction<=instruction; if_pc<=program_counter; if_valid<=1;
//                     PC<=(PC==LAST_ADDR)?0:PC+1.
//  HALTED: all outputs hold except if_valid=0, running=0; exits only via RST.
//  Latency: instruction memory read is combinational, so if_instruction is valid one edge after
//   program_counter presents the address; throughput 1 word/cycle with no stall.
//  Arithmetic: PC increment in PC_WIDTH bits; wrap by compare to LAST_ADDR, not overflow.
//  Unused: branch_target ignored when branch_taken=0; branch_taken ignored outside RUN.
//  running=1 exactly while state==RUN; pc_fault is 0 in every state except fault cycle.
// TESTING
//  T1 reset, load_done=0 for 20 cycles -> PC=0, if_valid=0, running=0 throughout.
//  T2 raise load_done, mem[0..2]=40AA,4107,0000 -> after 2 edges if_instruction=40AA,if_pc=0,
//     then 4107/1, 0000/2 on consecutive edges, if_valid=1.
//  T3 run to PC=31 -> if_pc=31 captured, next program_counter=0 (wrap), no gap in if_valid.
//  T4 stall 3 cycles at PC=5 -> PC=5, if_pc=4 held; stall+branch_taken(target=10) same
//     cycle -> PC=10, if_valid=0 next cycle, then if_pc=10.
//  T5 branch_taken target=0x40 -> PC=0, pc_fault high exactly one cycle, if_valid=0.
//  T6 halt at PC=7 -> HALTED, if_valid=0, PC stays 7; assert RST mid-run -> outputs reset
//     immediately without clock edge.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: instruction-memory port, pipeline control inputs and IF/ID outputs.
// The slave modport is the fetch sequencer. The master modport is the surrounding core and memory.
interface fetch_sequencer_if #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16
);
   logic                   load_done;
   logic [INSTR_WIDTH-1:0] instruction;
   logic                   stall;
   logic                   branch_taken;
   logic [PC_WIDTH-1:0]    branch_target;
   logic                   halt;
   logic [PC_WIDTH-1:0]    program_counter;
   logic [INSTR_WIDTH-1:0] if_instruction;
   logic [PC_WIDTH-1:0]    if_pc;
   logic                   if_valid;
   logic                   running;
   logic                   pc_fault;

   modport slave (
      input  load_done, instruction, stall, branch_taken, branch_target, halt,
      output program_counter, if_instruction, if_pc, if_valid, running, pc_fault
   );

   modport master (
      output load_done, instruction, stall, branch_taken, branch_target, halt,
      input  program_counter, if_instruction, if_pc, if_valid, running, pc_fault
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage. It waits for the memory load, then streams one word per cycle into the IF/ID register.
// It also handles stall, branch redirect and flush, halt, and out-of-range branch targets.
module fetch_sequencer #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16,
   parameter int RESET_PC    = 0,
   parameter int LAST_ADDR   = 31
) (
   input  logic              CLK,
   input  logic              RST,
   fetch_sequencer_if.slave  bus
);
   localparam logic [PC_WIDTH-1:0] RESET_V = PC_WIDTH'(RESET_PC);
   localparam logic [PC_WIDTH-1:0] LAST_V  = PC_WIDTH'(LAST_ADDR);

   typedef enum logic [1:0] {
      WAIT_LOAD = 2'd0,
      RUN       = 2'd1,
      HALTED    = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [PC_WIDTH-1:0]    r_pc;
   logic [INSTR_WIDTH-1:0] r_if_instr;
   logic [PC_WIDTH-1:0]    r_if_pc;
   logic                   r_if_valid;
   logic                   r_pc_fault;
   logic                   w_running;
   logic                   w_target_ok;
   logic [PC_WIDTH-1:0]    w_pc_seq;

   assign w_target_ok = (bus.branch_target <= LAST_V);
   // Wrap by address compare, so memories smaller than 2**PC_WIDTH work.
   assign w_pc_seq    = (r_pc == LAST_V) ? '0 : r_pc + 1'b1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= WAIT_LOAD;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_LOAD: if (bus.load_done) w_state_nxt = RUN;
         RUN: begin
            if (bus.halt)            w_state_nxt = HALTED;
            else if (!bus.load_done) w_state_nxt = WAIT_LOAD;
         end
         HALTED:    w_state_nxt = HALTED;
         default:   w_state_nxt = WAIT_LOAD;
      endcase
   end

   always_comb begin
      w_running = (r_state == RUN);
   end

   // Datapath. The branch redirect outranks stall, so a flush is never lost behind a stalled decoder.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pc       <= RESET_V;
         r_if_instr <= '0;
         r_if_pc    <= '0;
         r_if_valid <= 1'b0;
         r_pc_fault <= 1'b0;
      end else begin
         r_pc_fault <= 1'b0;
         case (r_state)
            RUN: begin
               if (bus.halt) begin
                  r_if_valid <= 1'b0;
               end else if (!bus.load_done) begin
                  r_pc       <= RESET_V;
                  r_if_valid <= 1'b0;
               end else if (bus.branch_taken) begin
                  r_if_valid <= 1'b0;
                  if (w_target_ok) begin
                     r_pc <= bus.branch_target;
                  end else begin
                     r_pc       <= RESET_V;
                     r_pc_fault <= 1'b1;
                  end
               end else if (!bus.stall) begin
                  r_if_instr <= bus.instruction;
                  r_if_pc    <= r_pc;
                  r_if_valid <= 1'b1;
                  r_pc       <= w_pc_seq;
               end
            end
            HALTED: begin
               r_if_valid <= 1'b0;
            end
            default: begin
               r_pc       <= RESET_V;
               r_if_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.program_counter = r_pc;
   assign bus.if_instruction  = r_if_instr;
   assign bus.if_pc           = r_if_pc;
   assign bus.if_valid        = r_if_valid;
   assign bus.running         = w_running;
   assign bus.pc_fault        = r_pc_fault;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. A combinational instruction memory is modelled with a preloaded array.
module tb_fetch_sequencer;
   logic        CLK;
   logic        RST;
   logic [15:0] mem [0:255];
   int          total;
   int          bad;

   fetch_sequencer_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();

   fetch_sequencer #(
      .PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(0), .LAST_ADDR(31)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   assign bus.instruction = mem[bus.program_counter];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_if(input string tag, input logic [15:0] instr, input logic [7:0] pc,
                         input logic vld, input logic [7:0] nxt_pc);
      chk({tag, "_instr"}, 32'(bus.if_instruction), 32'(instr));
      chk({tag, "_ifpc"},  32'(bus.if_pc),          32'(pc));
      chk({tag, "_vld"},   32'(bus.if_valid),       32'(vld));
      chk({tag, "_pc"},    32'(bus.program_counter), 32'(nxt_pc));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
      mem[0] = 16'h40AA;
      mem[1] = 16'h4107;
      mem[2] = 16'h0000;

      RST               = 1'b1;
      bus.load_done     = 1'b0;
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 8'h00;
      bus.halt          = 1'b0;
      #2;
      chk_if("reset", 16'h0000, 8'h00, 1'b0, 8'h00);
      chk("reset_run",   32'(bus.running),  32'(0));
      chk("reset_fault", 32'(bus.pc_fault), 32'(0));
      @(negedge CLK);
      RST = 1'b0;

      // T1: waiting for the memory load
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t1_pc",  32'(bus.program_counter), 32'(0));
         chk("t1_vld", 32'(bus.if_valid),        32'(0));
         chk("t1_run", 32'(bus.running),         32'(0));
      end

      // T2: first fetches
      bus.load_done = 1'b1;
      tick();
      chk("t2_run", 32'(bus.running), 32'(1));
      chk("t2_vld0", 32'(bus.if_valid), 32'(0));
      chk("t2_pc0", 32'(bus.program_counter), 32'(0));
      tick(); chk_if("t2_w0", 16'h40AA, 8'd0, 1'b1, 8'd1);
      tick(); chk_if("t2_w1", 16'h4107, 8'd1, 1'b1, 8'd2);
      tick(); chk_if("t2_w2", 16'h0000, 8'd2, 1'b1, 8'd3);

      // T3: stream up to the last address and wrap
      for (int a = 3; a <= 31; a++) begin
         tick();
         chk("t3_ifpc", 32'(bus.if_pc), 32'(a));
         chk("t3_vld",  32'(bus.if_valid), 32'(1));
      end
      chk_if("t3_last", 16'hA01F, 8'd31, 1'b1, 8'd0);
      tick(); chk_if("t3_wrap", 16'h40AA, 8'd0, 1'b1, 8'd1);
      for (int i = 0; i < 4; i++) tick();
      chk_if("t4_pre", 16'hA004, 8'd4, 1'b1, 8'd5);

      // T4: stall, then branch under stall
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_if("t4_stall", 16'hA004, 8'd4, 1'b1, 8'd5);
      end
      bus.branch_taken  = 1'b1;
      bus.branch_target = 8'd10;
      tick();
      chk("t4_br_pc",  32'(bus.program_counter), 32'(10));
      chk("t4_br_vld", 32'(bus.if_valid),        32'(0));
      chk("t4_br_flt", 32'(bus.pc_fault),        32'(0));
      bus.branch_taken = 1'b0;
      bus.stall        = 1'b0;
      tick(); chk_if("t4_tgt", 16'hA00A, 8'd10, 1'b1, 8'd11);

      // T5: out-of-range target
      bus.branch_taken  = 1'b1;
      bus.branch_target = 8'h40;
      tick();
      chk("t5_pc",    32'(bus.program_counter), 32'(0));
      chk("t5_fault", 32'(bus.pc_fault),        32'(1));
      chk("t5_vld",   32'(bus.if_valid),        32'(0));
      bus.branch_taken = 1'b0;
      tick();
      chk("t5_fault_clr", 32'(bus.pc_fault), 32'(0));
      chk_if("t5_after", 16'h40AA, 8'd0, 1'b1, 8'd1);

      // T6: halt, branch ignored while halted
      for (int i = 0; i < 6; i++) tick();
      chk("t6_pc7", 32'(bus.program_counter), 32'(7));
      bus.halt = 1'b1;
      tick();
      chk("t6_run", 32'(bus.running),  32'(0));
      chk("t6_vld", 32'(bus.if_valid), 32'(0));
      chk("t6_pc",  32'(bus.program_counter), 32'(7));
      bus.halt          = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 8'd3;
      tick(); tick();
      chk("t6_hold_pc",  32'(bus.program_counter), 32'(7));
      chk("t6_hold_run", 32'(bus.running),         32'(0));
      chk("t6_hold_if",  32'(bus.if_pc),           32'(6));
      bus.branch_taken = 1'b0;

      // Leave HALTED via reset, then test the memory-reload exit
      RST = 1'b1;
      #1;
      RST = 1'b0;
      tick();
      chk("rl_run", 32'(bus.running), 32'(1));
      tick(); tick();
      chk_if("rl_fetch", 16'h4107, 8'd1, 1'b1, 8'd2);
      bus.load_done = 1'b0;
      tick();
      chk("rl_wait_run", 32'(bus.running), 32'(0));
      chk("rl_wait_vld", 32'(bus.if_valid), 32'(0));
      chk("rl_wait_pc",  32'(bus.program_counter), 32'(0));
      bus.load_done = 1'b1;
      tick(); tick(); tick(); tick();
      chk_if("rl_mid", 16'h0000, 8'd2, 1'b1, 8'd3);

      // Asynchronous reset mid-cycle, with no clock edge
      #2;
      RST = 1'b1;
      #1;
      chk_if("arst", 16'h0000, 8'd0, 1'b0, 8'd0);
      chk("arst_run", 32'(bus.running), 32'(0));
      RST = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
